// File: rtl/snail_pkg.sv
// Shared types and constants for the SNAIL serial front end.
package snail_pkg;

  localparam int SNAIL_SER_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } snail_ser_state_t;

endpackage

// File: rtl/snail_serializer_if.sv
// Word handshake in, serial bit stream out, between a word source and the SNAIL serializer.
interface snail_serializer_if import snail_pkg::*; #(
  parameter int WIDTH = SNAIL_SER_WIDTH
) ();

  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             a;
  logic             a_valid;
  logic             busy;

  modport master (
    output din, din_valid,
    input  din_ready, a, a_valid, busy
  );

  modport slave (
    input  din, din_valid,
    output din_ready, a, a_valid, busy
  );

endinterface

// File: rtl/snail_hold_reg.sv
// One-entry word buffer with full flag; a simultaneous load and drain keeps it full with the new word.
module snail_hold_reg import snail_pkg::*; #(
  parameter int WIDTH = SNAIL_SER_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             drain,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic [WIDTH-1:0] dout
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full <= 1'b0;
      dout <= '0;
    end else begin
      if (load) begin
        dout <= din;
        full <= 1'b1;
      end else if (drain) begin
        full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/snail_serializer.sv
// MSB-first parallel-to-serial front end for the SNAIL recogniser.
// Define SNAIL_SER_BUF_EN to add a one-entry holding register for gapless streaming.
//
//   state | meaning
//   IDLE  | no word in flight, line held quiet at 0
//   SHIFT | word in flight, shreg MSB on the line, cnt = bit index
module snail_serializer import snail_pkg::*; #(
  parameter int WIDTH = SNAIL_SER_WIDTH
) (
  input  logic               clk,
  input  logic               reset_n,
  snail_serializer_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  snail_ser_state_t state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             last;
  logic             xfer;
  logic             hold_full;
  logic [WIDTH-1:0] hold_data;

  assign last = (state == SHIFT) && (cnt == LAST);
  assign xfer = bus.din_valid && bus.din_ready;

`ifdef SNAIL_SER_BUF_EN
  logic hold_load;
  logic hold_drain;

  // On the last-bit edge an empty hold is bypassed; a full one drains while taking any new word.
  assign hold_drain    = last && hold_full;
  assign hold_load     = xfer && (state == SHIFT) && (!last || hold_full);
  assign bus.din_ready = reset_n && !hold_full;

  snail_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (hold_load),
    .drain   (hold_drain),
    .din     (bus.din),
    .full    (hold_full),
    .dout    (hold_data)
  );
`else
  assign hold_full     = 1'b0;
  assign hold_data     = '0;
  assign bus.din_ready = reset_n && ((state == IDLE) || last);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      shreg <= shreg_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (xfer) begin
          shreg_nxt = bus.din;
          cnt_nxt   = '0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        shreg_nxt = shreg << 1;
        cnt_nxt   = cnt + 1'b1;
        if (last) begin
          cnt_nxt = '0;
          if (hold_full) begin
            shreg_nxt = hold_data;
          end else if (xfer) begin
            shreg_nxt = bus.din;
          end else begin
            // The final shift has emptied shreg, so the line is already quiet.
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        shreg_nxt = '0;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign bus.a       = shreg[WIDTH-1];
  assign bus.a_valid = (state == SHIFT);
  assign bus.busy    = (state == SHIFT) || hold_full;

endmodule

// File: tb/tb_snail_serializer.sv
// Bench for snail_serializer: WIDTH=8 and WIDTH=4 instances against a bit-queue reference model.
module tb_snail_serializer;

`ifdef SNAIL_SER_BUF_EN
  localparam bit BUF = 1'b1;
`else
  localparam bit BUF = 1'b0;
`endif

  logic clk;
  logic reset_n;

  snail_serializer_if #(.WIDTH(8)) bus8 ();
  snail_serializer_if #(.WIDTH(4)) bus4 ();

  snail_serializer #(.WIDTH(8)) dut8 (.clk(clk), .reset_n(reset_n), .bus(bus8));
  snail_serializer #(.WIDTH(4)) dut4 (.clk(clk), .reset_n(reset_n), .bus(bus4));

  // Per-instance queue of bits still owed on the serial line, MSB of each word first.
  bit q [2][$];
  int acc [2];
  int n_checks;
  int n_fail;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int width_of(input int d);
    return (d == 0) ? 8 : 4;
  endfunction

  // Outstanding bits after this cycle's bit is consumed: no-buffer mode takes a word only
  // when nothing is left, buffered mode while less than one full word is left.
  function automatic bit model_ready(input int d);
    if (!reset_n) return 1'b0;
    if (BUF) return q[d].size() < width_of(d);
    return q[d].size() == 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int d, input logic v, input logic [31:0] w);
    if (d == 0) begin
      bus8.din_valid = v;
      bus8.din       = w[7:0];
    end else begin
      bus4.din_valid = v;
      bus4.din       = w[3:0];
    end
  endtask

  always @(posedge clk) begin
    if (reset_n && bus8.din_valid && model_ready(0)) begin
      for (int i = 7; i >= 0; i--) q[0].push_back(bus8.din[i]);
      acc[0]++;
    end
    if (reset_n && bus4.din_valid && model_ready(1)) begin
      for (int i = 3; i >= 0; i--) q[1].push_back(bus4.din[i]);
      acc[1]++;
    end
  end

  task automatic mon(input int d, input logic a, input logic av, input logic bsy, input logic rdy);
    string p;
    bit ev;
    bit e;
    p = $sformatf("w%0d", width_of(d));
    if (!reset_n) begin
      chk({p, " a in reset"}, a, 0);
      chk({p, " a_valid in reset"}, av, 0);
      chk({p, " busy in reset"}, bsy, 0);
      chk({p, " din_ready in reset"}, rdy, 0);
    end else begin
      ev = q[d].size() > 0;
      chk({p, " a_valid"}, av, ev);
      chk({p, " busy"}, bsy, ev);
      if (ev) begin
        e = q[d].pop_front();
        chk({p, " a bit"}, a, e);
      end else begin
        chk({p, " a idle"}, a, 0);
      end
      chk({p, " din_ready"}, rdy, model_ready(d));
    end
  endtask

  always @(negedge clk) begin
    mon(0, bus8.a, bus8.a_valid, bus8.busy, bus8.din_ready);
    mon(1, bus4.a, bus4.a_valid, bus4.busy, bus4.din_ready);
  end

  task automatic send(input int d, input logic [31:0] w);
    int n0;
    n0 = acc[d];
    drive(d, 1'b1, w);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (acc[d] != n0) break;
    end
    chk($sformatf("w%0d accept %0h", width_of(d), w), 32'(acc[d] != n0), 1);
    drive(d, 1'b0, 0);
  endtask

  task automatic wait_idle(input int d);
    for (int i = 0; i < 200; i++) begin
      if (q[d].size() == 0) break;
      @(negedge clk);
      #1;
    end
    chk($sformatf("w%0d drained", width_of(d)), q[d].size(), 0);
    repeat (2) @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t exceeded limit", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    acc[0]   = 0;
    acc[1]   = 0;
    drive(0, 1'b0, 0);
    drive(1, 1'b0, 0);
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    #1;

    // single word 1101_1000
    send(0, 32'hD8);
    wait_idle(0);

    // FF then 00 presented on the last-bit cycle: gapless 16 bits
    send(0, 32'hFF);
    send(0, 32'h00);
    wait_idle(0);

    // three words streamed back to back
    send(0, 32'hA5);
    send(0, 32'h3C);
    send(0, 32'hF0);
    wait_idle(0);

    // reset mid-word after 3 bits of E7
    send(0, 32'hE7);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async reset a", bus8.a, 0);
    chk("async reset a_valid", bus8.a_valid, 0);
    chk("async reset busy", bus8.busy, 0);
    chk("async reset din_ready", bus8.din_ready, 0);
    q[0].delete();
    q[1].delete();
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    #1;
    send(0, 32'h81);
    wait_idle(0);

    // narrow instance, 0110
    send(1, 32'h6);
    wait_idle(1);

    // random valid toggling with data changing every cycle, including while stalled
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      drive(0, 1'($urandom_range(0, 1)), $urandom);
      drive(1, 1'($urandom_range(0, 3) == 0), $urandom);
    end
    drive(0, 1'b0, 0);
    drive(1, 1'b0, 0);
    wait_idle(0);
    wait_idle(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
